// File: rtl/elm_neuron_mac_pkg.sv
// elm_neuron_mac_pkg: activation encodings, FSM states
// and the round/saturate helper shared by the neuron.
package elm_neuron_mac_pkg;

  localparam logic [1:0] ACT_IDENTITY = 2'd0;
  localparam logic [1:0] ACT_RELU     = 2'd1;
  localparam logic [1:0] ACT_HSIG     = 2'd2;

  // Wide signed scratch width for rounding math.
  localparam int SAT_W = 64;
  localparam logic signed [SAT_W-1:0] SONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_FINAL,
    ST_OUT
  } state_e;

  // Round half up by frac_w bits, then clamp to a
  // signed data_w range. s holds an acc_w-bit value.
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] s,
    input int acc_w,
    input int data_w,
    input int frac_w
  );
    logic signed [SAT_W-1:0] x;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    x  = s <<< (SAT_W - acc_w);
    x  = x >>> (SAT_W - acc_w);
    r  = (x + (SONE <<< (frac_w - 1))) >>> frac_w;
    hi = (SONE <<< (data_w - 1)) - SONE;
    lo = -(SONE <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/elm_weight_ram.sv
// elm_weight_ram: 1W/1R synchronous weight store.
// Contents are never reset so weights survive rst.
module elm_weight_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 128,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read, one cycle of latency.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/elm_neuron_mac.sv
// elm_neuron_mac: one ELM neuron, streaming MAC with
// bias, round/saturate and selectable activation.
module elm_neuron_mac
  import elm_neuron_mac_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_INPUTS = 128,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int CFG_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CFG_W-1:0]  cfg_layer_num,
  input  logic [CFG_W-1:0]  cfg_neuron_num,
  input  logic              weight_valid,
  input  logic [DATA_W-1:0] weight_value,
  input  logic              bias_valid,
  input  logic [DATA_W-1:0] bias_value,
  input  logic [1:0]        act_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              weights_loaded
);

  localparam int AW    = $clog2(NUM_INPUTS);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + AW;
  localparam int S_W   = ACC_W + 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_INPUTS - 1);

  state_e state_q, state_d;

  logic [AW-1:0] rcnt_q;
  logic [1:0]    dcnt_q;
  logic [AW-1:0] wptr_q;
  logic          wl_q;
  logic [1:0]    act_q;

  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] x0_q;
  logic signed [DATA_W-1:0] x1_q;
  logic [AW-1:0]            a0_q;
  logic                     v0_q;
  logic                     v1_q;
  logic                     v2_q;
  logic signed [PW-1:0]     prod_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic accept;
  logic id_hit;
  logic ld_en;
  logic we;
  logic done;

  logic signed [DATA_W-1:0] w_rd;
  logic signed [S_W-1:0]    s_full;
  logic signed [SAT_W-1:0]  sat;
  logic signed [DATA_W-1:0] v_sat;
  logic signed [SAT_W-1:0]  vx;
  logic signed [SAT_W-1:0]  hs;
  logic [DATA_W-1:0]        act_d;

  assign accept = in_valid & in_ready;
  assign id_hit = (cfg_layer_num == CFG_W'(LAYER_NO))
                & (cfg_neuron_num == CFG_W'(NEURON_NO));
  assign ld_en  = (state_q == ST_IDLE) & id_hit;
  assign we     = ld_en & weight_valid;
  assign done   = (state_q == ST_OUT)
                & out_valid_q & out_ready;

  elm_weight_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_INPUTS)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (weight_value),
    .raddr_i (a0_q),
    .rdata_o (w_rd)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (accept && rcnt_q == LAST) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 2'd2) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: input side is open in IDLE/ACCUM only.
  always_comb begin
    in_ready = ((state_q == ST_IDLE)
             | (state_q == ST_ACCUM)) & ~rst;
  end

  // Element and drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (accept) begin
        if (state_q == ST_IDLE) begin
          rcnt_q <= AW'(1);
        end else if (rcnt_q == LAST) begin
          rcnt_q <= '0;
        end else begin
          rcnt_q <= rcnt_q + AW'(1);
        end
      end
      if (state_q == ST_DRAIN) begin
        dcnt_q <= dcnt_q + 2'd1;
      end else begin
        dcnt_q <= '0;
      end
    end
  end

  // Weight/bias loading, only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      wl_q   <= 1'b0;
      bias_q <= '0;
    end else begin
      if (we) begin
        if (wptr_q == LAST) begin
          wptr_q <= '0;
          wl_q   <= 1'b1;
        end else begin
          wptr_q <= wptr_q + AW'(1);
        end
      end
      if (ld_en && bias_valid) begin
        bias_q <= bias_value;
      end
    end
  end

  // Activation mode is frozen on the first element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= ACT_IDENTITY;
    end else if (accept && state_q == ST_IDLE) begin
      act_q <= act_mode;
    end
  end

  // MAC pipeline: capture, read, multiply, accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      x0_q   <= '0;
      x1_q   <= '0;
      a0_q   <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        x0_q <= in_data;
        a0_q <= rcnt_q;
      end
      v1_q <= v0_q;
      x1_q <= x0_q;
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q <= PW'(x1_q) * PW'(w_rd);
      end
      if (done) begin
        acc_q <= '0;
      end else if (v2_q) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
    end
  end

  assign s_full = S_W'(acc_q)
                + (S_W'(bias_q) <<< FRAC_W);
  assign sat    = sat_round(SAT_W'(s_full), S_W,
                            DATA_W, FRAC_W);
  assign v_sat  = sat[DATA_W-1:0];

  // Activation applied to the saturated sum.
  always_comb begin
    vx = SAT_W'(v_sat);
    hs = (vx >>> 2) + (SONE <<< (FRAC_W - 1));
    if (hs < 0) begin
      hs = '0;
    end else if (hs > (SONE <<< FRAC_W)) begin
      hs = SONE <<< FRAC_W;
    end
    case (act_q)
      ACT_RELU: act_d = v_sat[DATA_W-1] ? '0 : v_sat;
      ACT_HSIG: act_d = hs[DATA_W-1:0];
      default:  act_d = v_sat;
    endcase
  end

  // Result register; valid trails entry into OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (state_q == ST_FINAL) begin
        out_data_q <= act_d;
      end
      out_valid_q <= (state_q == ST_OUT) & ~done;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign weights_loaded = wl_q;

endmodule

// File: tb/tb_elm_neuron_mac.sv
// tb_elm_neuron_mac: directed and random vectors
// against an arithmetic model of the neuron.
module tb_elm_neuron_mac;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_layer_num = 32'd1;
  logic [31:0] cfg_neuron_num = 32'd0;
  logic        weight_valid = 1'b0;
  logic [15:0] weight_value = '0;
  logic        bias_valid = 1'b0;
  logic [15:0] bias_value = '0;
  logic [1:0]  act_mode = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        weights_loaded;

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] wm [NI];
  logic signed [15:0] xm [NI];
  logic signed [15:0] bm = '0;
  logic [6:0] gap_pat = 7'b1011001;

  always #5 clk = ~clk;

  elm_neuron_mac #(
    .DATA_W     (16),
    .FRAC_W     (8),
    .NUM_INPUTS (NI),
    .LAYER_NO   (1),
    .NEURON_NO  (0),
    .CFG_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_layer_num  (cfg_layer_num),
    .cfg_neuron_num (cfg_neuron_num),
    .weight_valid   (weight_valid),
    .weight_value   (weight_value),
    .bias_valid     (bias_valid),
    .bias_value     (bias_value),
    .act_mode       (act_mode),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .weights_loaded (weights_loaded)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Real-number neuron: dot product, bias, round, clamp.
  function automatic logic [15:0] model(
    input logic [1:0] m);
    longint s;
    longint r;
    longint h;
    s = 0;
    for (int i = 0; i < NI; i++)
      s += longint'(wm[i]) * longint'(xm[i]);
    s += longint'(bm) * 256;
    r = (s + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (m == 2'd1 && r < 0) r = 0;
    if (m == 2'd2) begin
      h = (r >>> 2) + 128;
      if (h < 0) h = 0;
      if (h > 256) h = 256;
      r = h;
    end
    return 16'(r);
  endfunction

  task automatic load_w(input logic [15:0] v,
                        input int lay, input int neu);
    @(negedge clk);
    cfg_layer_num  = 32'(lay);
    cfg_neuron_num = 32'(neu);
    weight_value   = v;
    weight_valid   = 1'b1;
    @(negedge clk);
    weight_valid   = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] v,
                        input int lay, input int neu);
    @(negedge clk);
    cfg_layer_num  = 32'(lay);
    cfg_neuron_num = 32'(neu);
    bias_value     = v;
    bias_valid     = 1'b1;
    @(negedge clk);
    bias_valid     = 1'b0;
  endtask

  task automatic set_all(input logic [15:0] w,
                         input logic [15:0] b);
    for (int i = 0; i < NI; i++) begin
      wm[i] = w;
      load_w(w, 1, 0);
    end
    bm = b;
    load_b(b, 1, 0);
  endtask

  // gmode: 0 back-to-back, 1 fixed gaps, 2 random gaps.
  task automatic run_vec(input logic [1:0] mode,
                         input int hold,
                         input int gmode);
    int idx;
    int cyc;
    int lat;
    bit ok;
    logic [15:0] exp;
    exp = model(mode);
    idx = 0;
    cyc = 0;
    while (idx < NI && cyc < 200) begin
      @(negedge clk);
      if (gmode == 1 && cyc < 7)
        in_valid = gap_pat[cyc];
      else if (gmode == 2)
        in_valid = ($urandom_range(0, 2) != 0);
      else
        in_valid = 1'b1;
      in_data  = in_valid ? xm[idx] : 16'($urandom);
      act_mode = (idx == 0) ? mode : 2'($urandom);
      ok = in_valid && in_ready;
      @(posedge clk);
      if (ok) idx++;
      cyc++;
    end
    check("accepted", 64'(idx), 64'(NI));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("drain_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'd5);
    for (int k = 0; k < hold; k++) begin
      check("hold_data", 64'(out_data), 64'(exp));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check("out_data", 64'(out_data), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_fall", 64'(out_valid), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wl", 64'(weights_loaded), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      wm[i] = 16'h0100;
      load_w(16'h0100, 1, 0);
    end
    check("wl_partial", 64'(weights_loaded), 64'd0);
    wm[3] = 16'h0100;
    load_w(16'h0100, 1, 0);
    check("wl_full", 64'(weights_loaded), 64'd1);
    bm = 16'h0080;
    load_b(16'h0080, 1, 0);

    for (int i = 0; i < NI; i++)
      xm[i] = 16'((i + 1) * 256);
    run_vec(2'd0, 0, 0);
    check("ident_10p5", 64'(out_data), 64'h0A80);
    run_vec(2'd2, 0, 0);
    run_vec(2'd3, 1, 0);

    set_all(16'hFF00, 16'h0080);
    run_vec(2'd1, 0, 0);
    run_vec(2'd0, 0, 0);
    check("ident_m9p5", 64'(out_data), 64'hF680);

    set_all(16'hFFC0, 16'h0000);
    for (int i = 0; i < NI; i++) xm[i] = 16'h0100;
    run_vec(2'd2, 0, 0);
    check("hsig_m1", 64'(out_data), 64'h0040);

    set_all(16'h7F00, 16'h7FFF);
    for (int i = 0; i < NI; i++) xm[i] = 16'h7F00;
    run_vec(2'd0, 0, 0);
    check("sat_pos", 64'(out_data), 64'h7FFF);
    set_all(16'h8100, 16'h7FFF);
    run_vec(2'd0, 0, 0);
    check("sat_neg", 64'(out_data), 64'h8000);

    set_all(16'h0100, 16'h0080);
    for (int i = 0; i < NI; i++)
      xm[i] = 16'((i + 1) * 256);
    run_vec(2'd0, 10, 1);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NI; i++) begin
        if (t[0])
          wm[i] = 16'($urandom);
        else
          wm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        load_w(wm[i], 1, 0);
        xm[i] = t[1] ? 16'($urandom)
                     : 16'($urandom_range(0, 1023)) - 16'd512;
      end
      bm = 16'($urandom_range(0, 2047)) - 16'd1024;
      load_b(bm, 1, 0);
      run_vec(2'($urandom), $urandom_range(0, 3), 2);
    end

    for (int i = 0; i < NI; i++)
      xm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = xm[k];
      act_mode = 2'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_data", 64'(out_data), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_wl", 64'(weights_loaded), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bm = '0;
    for (int i = 0; i < NI; i++)
      load_w(16'h1234, 1, 1);
    load_w(16'h5678, 2, 0);
    load_b(16'h7000, 1, 1);
    check("miss_wl", 64'(weights_loaded), 64'd0);
    run_vec(2'd0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
